// File: rtl/operand_store.sv
// -----------------------------------------------------------------------------
// operand_store
//   Operand register file for the calculator datapath. Keypad digits are
//   collected into N_OPS operands of N_DIG digits each. Entry is either
//   positional (first digit lands in d0) or shift-in (new digit always lands in
//   d0 and older digits move up). A result can be written back into operand
//   SAVE_OP, which then locks that operand against further editing until it is
//   restarted.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active high
//   start    : pulse, clear operand op_sel and make it active
//   op_sel   : operand index used by start
//   dig_vld  : pulse, digit key pressed
//   digit    : digit value sampled with dig_vld
//   bksp     : pulse, delete last digit of the active operand
//   save     : pulse, load res_in into operand SAVE_OP
//   res_in   : result digits, d0 in [DIG_W-1:0]
//   ops      : all operands, operand o digit i at [(o*N_DIG+i)*DIG_W +: DIG_W]
//   active   : index of the active operand
//   cnt      : digits held by the active operand
//   full     : active operand holds N_DIG digits
//   locked   : active operand was loaded by save
//   drop     : 1-cycle pulse, digit rejected (full or locked)
//   err      : 1-cycle pulse, digit > DIG_MAX or op_sel out of range
// -----------------------------------------------------------------------------
module operand_store #(
    parameter int N_DIG    = 4,
    parameter int N_OPS    = 2,
    parameter int DIG_W    = 4,
    parameter int DIG_MAX  = 9,
    parameter int SEL_W    = 1,
    parameter int SHIFT_MD = 0,
    parameter int SAVE_OP  = 0,
    localparam int CNT_W   = $clog2(N_DIG + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [SEL_W-1:0]               op_sel,
    input  logic                           dig_vld,
    input  logic [DIG_W-1:0]               digit,
    input  logic                           bksp,
    input  logic                           save,
    input  logic [N_DIG*DIG_W-1:0]         res_in,
    output logic [N_OPS*N_DIG*DIG_W-1:0]   ops,
    output logic [SEL_W-1:0]               active,
    output logic [CNT_W-1:0]               cnt,
    output logic                           full,
    output logic                           locked,
    output logic                           drop,
    output logic                           err
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_DIG);
    localparam logic [SEL_W:0]   OPS_LIM  = (SEL_W + 1)'(N_OPS);
    localparam logic [DIG_W-1:0] DIG_LIM  = DIG_W'(DIG_MAX);
    localparam logic [SEL_W-1:0] SAVE_IDX = SEL_W'(SAVE_OP);

    logic [DIG_W-1:0] r_dig [N_OPS][N_DIG];
    logic [CNT_W-1:0] r_cnt [N_OPS];
    logic [N_OPS-1:0] r_lock;
    logic [SEL_W-1:0] r_active;
    logic             r_drop;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt;
    logic             w_lock;
    logic             w_sel_ok;
    logic             w_dig_bad;
    logic [DIG_W-1:0] w_ins [N_DIG];   // active operand after accepting digit
    logic [DIG_W-1:0] w_del [N_DIG];   // active operand after backspace

    assign w_cnt     = r_cnt[r_active];
    assign w_lock    = r_lock[r_active];
    assign w_sel_ok  = ({1'b0, op_sel} < OPS_LIM);
    assign w_dig_bad = (digit > DIG_LIM);

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_dig
            if (SHIFT_MD != 0) begin : g_shift
                // Shift-in: insert pushes everything up, backspace pulls down.
                if (gi == 0) begin : g_lo
                    assign w_ins[gi] = digit;
                end else begin : g_up
                    assign w_ins[gi] = r_dig[r_active][gi-1];
                end
                if (gi == N_DIG - 1) begin : g_top
                    assign w_del[gi] = '0;
                end else begin : g_dn
                    assign w_del[gi] = r_dig[r_active][gi+1];
                end
            end else begin : g_pos
                // Positional: only the slot addressed by the count changes.
                assign w_ins[gi] = (w_cnt == CNT_W'(gi))     ? digit : r_dig[r_active][gi];
                assign w_del[gi] = (w_cnt == CNT_W'(gi + 1)) ? '0    : r_dig[r_active][gi];
            end
        end

        for (gi = 0; gi < N_OPS; gi++) begin : g_op_out
            for (gj = 0; gj < N_DIG; gj++) begin : g_dig_out
                assign ops[(gi*N_DIG + gj)*DIG_W +: DIG_W] = r_dig[gi][gj];
            end
        end
    endgenerate

    // One event per cycle, highest priority wins; the rest are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N_OPS; o++) begin
                for (int i = 0; i < N_DIG; i++) begin
                    r_dig[o][i] <= '0;
                end
                r_cnt[o] <= '0;
            end
            r_lock   <= '0;
            r_active <= '0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            r_err  <= 1'b0;
            if (save) begin
                for (int i = 0; i < N_DIG; i++) begin
                    r_dig[SAVE_OP][i] <= res_in[i*DIG_W +: DIG_W];
                end
                r_cnt[SAVE_OP]  <= FULL_CNT;
                r_lock[SAVE_OP] <= 1'b1;
                r_active        <= SAVE_IDX;
            end else if (start) begin
                if (w_sel_ok) begin
                    for (int i = 0; i < N_DIG; i++) begin
                        r_dig[op_sel][i] <= '0;
                    end
                    r_cnt[op_sel]  <= '0;
                    r_lock[op_sel] <= 1'b0;
                    r_active       <= op_sel;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (bksp) begin
                if ((w_cnt != '0) && !w_lock) begin
                    r_dig[r_active] <= w_del;
                    r_cnt[r_active] <= w_cnt - CNT_W'(1);
                end
            end else if (dig_vld) begin
                if (w_dig_bad) begin
                    r_err <= 1'b1;
                end else if (w_lock || (w_cnt == FULL_CNT)) begin
                    r_drop <= 1'b1;
                end else begin
                    r_dig[r_active] <= w_ins;
                    r_cnt[r_active] <= w_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign active = r_active;
    assign cnt    = w_cnt;
    assign full   = (w_cnt == FULL_CNT);
    assign locked = w_lock;
    assign drop   = r_drop;
    assign err    = r_err;

endmodule

// File: tb/tb_operand_store.sv
// -----------------------------------------------------------------------------
// tb_operand_store
//   Drives two instances from one stimulus stream: a default positional one
//   (2 operands, save into operand 0) and a shift-in one (3 operands, 2-bit
//   select, save into operand 2). The reference model keeps each operand as
//   the list of digits in entry order plus a lock flag; the register image is
//   derived from that list.
// -----------------------------------------------------------------------------
module tb_operand_store;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        save = 1'b0;
    logic        start = 1'b0;
    logic        bksp = 1'b0;
    logic        dig_vld = 1'b0;
    logic [1:0]  op_sel = '0;
    logic [3:0]  digit = '0;
    logic [15:0] res_in = '0;

    logic [31:0] ops_p;
    logic [0:0]  act_p;
    logic [2:0]  cnt_p;
    logic        full_p, lock_p, drop_p, err_p;

    logic [47:0] ops_s;
    logic [1:0]  act_s;
    logic [2:0]  cnt_s;
    logic        full_s, lock_s, drop_s, err_s;

    always #5 clk = ~clk;

    operand_store u_pos (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel[0]), .dig_vld(dig_vld),
        .digit(digit), .bksp(bksp), .save(save), .res_in(res_in),
        .ops(ops_p), .active(act_p), .cnt(cnt_p), .full(full_p),
        .locked(lock_p), .drop(drop_p), .err(err_p)
    );

    operand_store #(.N_OPS(3), .SEL_W(2), .SHIFT_MD(1), .SAVE_OP(2)) u_shf (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dig_vld(dig_vld),
        .digit(digit), .bksp(bksp), .save(save), .res_in(res_in),
        .ops(ops_s), .active(act_s), .cnt(cnt_s), .full(full_s),
        .locked(lock_s), .drop(drop_s), .err(err_s)
    );

    // Reference model: index 0 = positional instance, 1 = shift-in instance.
    int m_list [2][3][4];
    int m_len  [2][3];
    bit m_lock [2][3];
    int m_act  [2];
    bit m_drop [2];
    bit m_err  [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        int n_ops, sv, sel, a;
        n_ops = (k == 0) ? 2 : 3;
        sv    = (k == 0) ? 0 : 2;
        sel   = (k == 0) ? int'(op_sel[0]) : int'(op_sel);
        a     = m_act[k];
        m_drop[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (rst) begin
            for (int o = 0; o < 3; o++) begin
                m_len[k][o]  = 0;
                m_lock[k][o] = 1'b0;
                for (int i = 0; i < 4; i++) m_list[k][o][i] = 0;
            end
            m_act[k] = 0;
        end else if (save) begin
            // Entry list order: positional = d0 first, shift-in = d3 first.
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (k == 0) ? i : 3 - i;
                m_list[k][sv][i] = int'(res_in[idx*4 +: 4]);
            end
            m_len[k][sv]  = 4;
            m_lock[k][sv] = 1'b1;
            m_act[k]      = sv;
        end else if (start) begin
            if (sel < n_ops) begin
                m_len[k][sel]  = 0;
                m_lock[k][sel] = 1'b0;
                m_act[k]       = sel;
            end else begin
                m_err[k] = 1'b1;
            end
        end else if (bksp) begin
            if (m_len[k][a] > 0 && !m_lock[k][a]) m_len[k][a]--;
        end else if (dig_vld) begin
            if (int'(digit) > 9) m_err[k] = 1'b1;
            else if (m_lock[k][a] || m_len[k][a] == 4) m_drop[k] = 1'b1;
            else begin
                m_list[k][a][m_len[k][a]] = int'(digit);
                m_len[k][a]++;
            end
        end
    endtask

    function automatic logic [63:0] exp_ops(input int k);
        logic [63:0] v;
        int n_ops, d;
        v = '0;
        n_ops = (k == 0) ? 2 : 3;
        for (int o = 0; o < n_ops; o++) begin
            for (int i = 0; i < 4; i++) begin
                d = 0;
                if (i < m_len[k][o])
                    d = (k == 0) ? m_list[k][o][i] : m_list[k][o][m_len[k][o]-1-i];
                v[(o*4 + i)*4 +: 4] = d[3:0];
            end
        end
        return v;
    endfunction

    task automatic step(input bit r, input bit sv, input bit st, input logic [1:0] sel,
                        input bit bk, input bit dv, input logic [3:0] dg, input logic [15:0] res);
        @(negedge clk);
        rst = r; save = sv; start = st; op_sel = sel;
        bksp = bk; dig_vld = dv; digit = dg; res_in = res;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check("P.ops",    64'(ops_p),  exp_ops(0));
        check("P.active", 64'(act_p),  64'(m_act[0]));
        check("P.cnt",    64'(cnt_p),  64'(m_len[0][m_act[0]]));
        check("P.full",   64'(full_p), 64'(m_len[0][m_act[0]] == 4));
        check("P.locked", 64'(lock_p), 64'(m_lock[0][m_act[0]]));
        check("P.drop",   64'(drop_p), 64'(m_drop[0]));
        check("P.err",    64'(err_p),  64'(m_err[0]));
        check("S.ops",    64'(ops_s),  exp_ops(1));
        check("S.active", 64'(act_s),  64'(m_act[1]));
        check("S.cnt",    64'(cnt_s),  64'(m_len[1][m_act[1]]));
        check("S.full",   64'(full_s), 64'(m_len[1][m_act[1]] == 4));
        check("S.locked", 64'(lock_s), 64'(m_lock[1][m_act[1]]));
        check("S.drop",   64'(drop_s), 64'(m_drop[1]));
        check("S.err",    64'(err_s),  64'(m_err[1]));
        $display("cyc %0d rst=%0b save=%0b start=%0b sel=%0d bksp=%0b dv=%0b dig=%0d | P ops=%h act=%0d cnt=%0d | S ops=%h act=%0d cnt=%0d",
                 cyc, r, sv, st, sel, bk, dv, dg, ops_p, act_p, cnt_p, ops_s, act_s, cnt_s);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_drop[k] = 0; m_err[k] = 0;
            for (int o = 0; o < 3; o++) begin
                m_len[k][o] = 0; m_lock[k][o] = 0;
                for (int i = 0; i < 4; i++) m_list[k][o][i] = 0;
            end
        end

        // Directed opening: reset state, fill, overflow, bad digit, backspace.
        step(1, 0, 0, 2'd0, 0, 0, 4'd0, 16'h0);
        step(0, 0, 1, 2'd0, 0, 0, 4'd0, 16'h0);
        for (int d = 1; d <= 5; d++) step(0, 0, 0, 2'd0, 0, 1, 4'(d), 16'h0);
        step(0, 0, 0, 2'd0, 0, 1, 4'hA, 16'h0);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 2'd0, 1, 0, 4'd0, 16'h0);
        // Save / lock / restart, then out-of-range select and a priority collision.
        step(0, 0, 1, 2'd1, 0, 0, 4'd0, 16'h0);
        step(0, 0, 0, 2'd0, 0, 1, 4'd7, 16'h0);
        step(0, 1, 0, 2'd0, 0, 0, 4'd0, 16'h9876);
        step(0, 0, 0, 2'd0, 0, 1, 4'd2, 16'h0);
        step(0, 0, 0, 2'd0, 1, 0, 4'd0, 16'h0);
        step(0, 0, 1, 2'd0, 0, 0, 4'd0, 16'h0);
        step(0, 0, 1, 2'd3, 0, 0, 4'd0, 16'h0);
        step(0, 1, 1, 2'd1, 1, 1, 4'hF, 16'h1234);
        // Reset mid-entry, then a digit with no start.
        for (int d = 1; d <= 3; d++) step(0, 0, 0, 2'd0, 0, 1, 4'(d), 16'h0);
        step(1, 0, 0, 2'd0, 0, 1, 4'd8, 16'h0);
        step(0, 0, 0, 2'd0, 0, 1, 4'd6, 16'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 12,
                 2'($urandom_range(3)), $urandom_range(99) < 20, $urandom_range(99) < 60,
                 4'($urandom_range(11)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
